// File: rtl/i2c_slave_read_byte.sv
// I2C slave byte receiver: drives the bit-read stage for BYTE_WIDTH bits, assembles them MSB-first and pulses finish.
// Optional build macro I2C_READ_BYTE_ERR_ABORT_EN aborts the byte on the first bit error instead of flagging it at finish.
module i2c_slave_read_byte #(
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  byte_read_en,
  output logic [BYTE_WIDTH-1:0] byte_read_o,
  output logic                  byte_read_err,
  output logic                  byte_read_finish,
  output logic                  bit_read_en,
  input  logic                  bit_read_i,
  input  logic                  bit_read_err_i,
  input  logic                  bit_read_finish_i,
  output logic [1:0]            fsm_state_o
);

  localparam int CW = $clog2(BYTE_WIDTH + 1);

  // Handshake: bit_read_en acts as "ready" toward the bit stage; bit_read_finish_i is a
  // one-cycle "valid" qualifying bit_read_i/bit_read_err_i and is consumed only in READ.
`ifdef I2C_READ_BYTE_ERR_ABORT_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_READ = 2'd1, ST_DONE = 2'd2, ST_ERR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_READ = 2'd1, ST_DONE = 2'd2} state_t;
`endif

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BYTE_WIDTH-1:0] shift_q, shift_d;
  logic [BYTE_WIDTH-1:0] byte_q, byte_d;
  logic                  fin_q, fin_d;
  logic                  err_out_q, err_out_d;
  logic                  bit_en_q, bit_en_d;
  logic                  last_bit;
`ifndef I2C_READ_BYTE_ERR_ABORT_EN
  logic                  sticky_q, sticky_d;
`endif

  assign last_bit = bit_read_finish_i && (cnt_q == CW'(BYTE_WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      fin_q     <= 1'b0;
      err_out_q <= 1'b0;
      bit_en_q  <= 1'b0;
`ifndef I2C_READ_BYTE_ERR_ABORT_EN
      sticky_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      fin_q     <= fin_d;
      err_out_q <= err_out_d;
      bit_en_q  <= bit_en_d;
`ifndef I2C_READ_BYTE_ERR_ABORT_EN
      sticky_q  <= sticky_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
`ifndef I2C_READ_BYTE_ERR_ABORT_EN
    sticky_d = sticky_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
`ifndef I2C_READ_BYTE_ERR_ABORT_EN
        sticky_d = 1'b0;
`endif
        if (byte_read_en) state_d = ST_READ;
      end
      ST_READ: begin
        if (!byte_read_en) begin
          // Abort drops the partial byte silently.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          if (bit_read_finish_i) begin
            shift_d = {shift_q[BYTE_WIDTH-2:0], bit_read_i};
            cnt_d   = cnt_q + CW'(1);
          end
`ifdef I2C_READ_BYTE_ERR_ABORT_EN
          if (bit_read_err_i) begin
            state_d = ST_ERR;
            cnt_d   = '0;
          end else if (last_bit) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end
`else
          if (bit_read_err_i) sticky_d = 1'b1;
          if (last_bit) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
`ifdef I2C_READ_BYTE_ERR_ABORT_EN
      ST_ERR: if (!byte_read_en) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one lines up with its state cycle.
  always_comb begin
    bit_en_d = (state_d == ST_READ);
    fin_d    = (state_d == ST_DONE);
    byte_d   = (state_d == ST_DONE) ? shift_d : byte_q;
`ifdef I2C_READ_BYTE_ERR_ABORT_EN
    err_out_d = (state_q == ST_READ) && (state_d == ST_ERR);
`else
    err_out_d = (state_d == ST_DONE) && sticky_d;
`endif
  end

  assign byte_read_o      = byte_q;
  assign byte_read_err    = err_out_q;
  assign byte_read_finish = fin_q;
  assign bit_read_en      = bit_en_q;
  assign fsm_state_o      = state_q;

endmodule

// File: doc/i2c_slave_read_byte.md
# i2c_slave_read_byte

Byte-level receive sequencer for the I2C slave datapath. Sits directly downstream of the slave bit-read stage: it holds that stage's enable high across eight SCL clocks and shifts in each sampled bit MSB-first on the stage's finish strobe. It then presents the assembled byte with a one-cycle finish pulse to the slave control FSM. Bit-level SDA-stability errors are aggregated into a byte-level error.

## Interface
Parameters:
- `BYTE_WIDTH`, default 8, number of bits per transfer (counter sized `$clog2(BYTE_WIDTH+1)`).

Ports:
- `clk`  input  1  system clock; all state is rising-edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `byte_read_en`  input  1  level enable from the control FSM. Must be raised at or after the SCL falling edge that precedes bit 7.
- `byte_read_o`  output  BYTE_WIDTH  assembled byte, MSB first; valid from the `byte_read_finish` cycle and held until the next finish.
- `byte_read_err`  output  1  byte-level error (see Configuration for its timing).
- `byte_read_finish`  output  1  one-cycle pulse, byte complete.
- `bit_read_en`  output  1  registered enable to the bit-read stage.
- `bit_read_i`  input  1  sampled bit from the bit-read stage.
- `bit_read_err_i`  input  1  combinational error from the bit-read stage.
- `bit_read_finish_i`  input  1  combinational finish strobe from the bit-read stage (SCL falling edge).

## Operation
- FSM states:
  - IDLE: `bit_read_en`=0; counter=0. Goes to READ when `byte_read_en`=1.
  - READ: `bit_read_en`=1.
    - On each `bit_read_finish_i`: shift register ← {shift[BYTE_WIDTH-2:0], `bit_read_i`}; counter+1.
    - When the counter reaches BYTE_WIDTH-1 and `bit_read_finish_i` is seen, go to DONE.
    - `byte_read_en`=0 in READ: go to IDLE, clear the counter, discard partial data, no finish and no error.
  - DONE: for one cycle, `byte_read_o` ← shift register and `byte_read_finish`=1. Then always go to IDLE.
  - ERR (only with the macro): `byte_read_err` pulsed on entry; stay until `byte_read_en`=0, then go to IDLE.
- `bit_read_err_i` and `bit_read_finish_i` are sampled only in READ and are ignored in every other state.
- Counter never wraps: it is cleared in IDLE and never exceeds BYTE_WIDTH-1.
- `byte_read_o` is updated only in DONE; partial bytes are never visible.
- Reset mid-byte: all state is cleared immediately (asynchronously); the next byte needs a fresh `byte_read_en`.

## Timing
- Reset values: `byte_read_o`=0, `byte_read_err`=0, `byte_read_finish`=0, `bit_read_en`=0, state=IDLE.
- `byte_read_en` rising in IDLE gives `bit_read_en`=1 on the next clock edge (1-cycle latency).
- An 8th `bit_read_finish_i` at edge N gives `byte_read_finish`=1 and `byte_read_o` valid in cycle N+1.
- `bit_read_en` falls in cycle N+1. If `byte_read_en` is still high, `bit_read_en` rises again at N+3. This lies after the SCL fall, so it satisfies the bit stage's enable rule.
- `byte_read_en` deasserted in READ gives `bit_read_en`=0 on the next edge.
- `bit_read_err_i` and `bit_read_finish_i` in the same cycle: the bit is shifted and counted, and the error is recorded. With the macro, the error wins and the state goes to ERR with no finish.

## Configuration
- `I2C_READ_BYTE_ERR_ABORT_EN` defined:
  - The first `bit_read_err_i` in READ goes to ERR on the next edge.
  - `byte_read_err` is a one-cycle pulse.
  - `bit_read_en` drops, `byte_read_o` is unchanged, and `byte_read_finish` is not asserted.
- `I2C_READ_BYTE_ERR_ABORT_EN` undefined:
  - `bit_read_err_i` sets a sticky flag, cleared in IDLE.
  - The byte always completes all BYTE_WIDTH bits.
  - `byte_read_err` equals the sticky flag during the `byte_read_finish` cycle only, and is 0 otherwise.
  - The ERR state is not built.

## Test plan
- Reset, then `byte_read_en`=1 and bits 1,0,1,0,0,1,0,1 delivered with finish strobes. Required: `byte_read_o`=8'hA5, one `byte_read_finish` pulse one cycle after the 8th strobe, and `byte_read_err`=0.
- `byte_read_en` held high across two bytes 8'h3C then 8'hFF. Required: two finish pulses, `bit_read_en` low for exactly 2 cycles between bytes, and correct data for each byte.
- `byte_read_en` dropped after 4 strobes, then a full byte 8'h81. Required: no finish on the aborted byte, `byte_read_o` stays at its prior value, then 8'h81.
- `bit_read_err_i` pulsed during bit 3, with the macro defined. Required: ERR reached, one `byte_read_err` pulse, no finish, `bit_read_en`=0 until `byte_read_en` is lowered.
- Same stimulus with the macro undefined. Required: byte completes, and `byte_read_err`=1 only in the finish cycle.
- `rst_n` asserted after 5 bits. Required: all outputs 0 immediately; the next byte 8'h55 reads correctly.
